// File: rtl/data_plane_rx.sv
// data_plane_rx: receives data-plane frames into a LIFO stack RAM and lets the GPP pop it.
module data_plane_rx #(
  parameter int PKT_WORDS = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       node_id,
  input  logic              data_rx_flag,
  input  logic [31:0]       data_rx_packet,
  output logic              data_rx_complete_flag,
  output logic              data_rx_error_flag,
  output logic [15:0]       rx_src_node,
  output logic              rx_overflow,
  input  logic              gpp_rx_pop,
  output logic [15:0]       gpp_rx_data,
  output logic              gpp_rx_valid,
  output logic [ADDR_W:0]   sp_rx_current
);
  localparam int CW = $clog2(PKT_WORDS + 1);
  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CW-1:0] LAST = CW'(PKT_WORDS - 1);
  typedef enum logic [1:0] {IDLE, WAIT_HDR, RECV} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_W:0] sp_q, sp_d, frame_sp_q, frame_sp_d, sp_m1;
  logic [15:0] src_q, src_d, rd_q, rd_d;
  logic ovf_q, ovf_d, cmp_q, cmp_d, err_q, err_d, vld_q, vld_d;
  logic hit, pop_ok, push;
  logic [15:0] mem [1 << ADDR_W];
  // node id 0 is reserved, so it never matches; this also rejects idle packets
  assign hit = data_rx_packet[31:16] == node_id && |node_id;
  assign pop_ok = gpp_rx_pop && state_q != RECV && |sp_q;
  assign push = state_q == RECV && hit && sp_q != FULL;
  assign sp_m1 = sp_q - 1'b1;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sp_d = pop_ok ? sp_m1 : sp_q;
    frame_sp_d = frame_sp_q;
    src_d = src_q;
    ovf_d = ovf_q;
    cmp_d = 1'b0;
    err_d = 1'b0;
    vld_d = pop_ok;
    rd_d = pop_ok ? mem[sp_m1[ADDR_W-1:0]] : rd_q;
    if (state_q == IDLE && data_rx_flag) state_d = WAIT_HDR;
    if (state_q == WAIT_HDR && hit) begin
      src_d = data_rx_packet[15:0];
      frame_sp_d = sp_d;
      cnt_d = '0;
      state_d = RECV;
    end
    if (state_q == RECV) begin
      if (hit) begin
        cnt_d = cnt_q + 1'b1;
        sp_d = push ? sp_q + 1'b1 : sp_q;
        ovf_d = ovf_q | ~push;
        cmp_d = cnt_q == LAST;
        state_d = cnt_q == LAST ? IDLE : RECV;
      end else begin
        sp_d = frame_sp_q;
        err_d = 1'b1;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sp_q <= '0;
      frame_sp_q <= '0;
      src_q <= '0;
      ovf_q <= 1'b0;
      cmp_q <= 1'b0;
      err_q <= 1'b0;
      vld_q <= 1'b0;
      rd_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sp_q <= sp_d;
      frame_sp_q <= frame_sp_d;
      src_q <= src_d;
      ovf_q <= ovf_d;
      cmp_q <= cmp_d;
      err_q <= err_d;
      vld_q <= vld_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) if (!rst && push) mem[sp_q[ADDR_W-1:0]] <= data_rx_packet[15:0];
  assign data_rx_complete_flag = cmp_q;
  assign data_rx_error_flag = err_q;
  assign rx_src_node = src_q;
  assign rx_overflow = ovf_q;
  assign gpp_rx_data = rd_q;
  assign gpp_rx_valid = vld_q;
  assign sp_rx_current = sp_q;
endmodule

// File: tb/tb_data_plane_rx.sv
// tb_data_plane_rx: directed checks of data_plane_rx at ADDR_W=4 and ADDR_W=2 driven in lockstep.
module tb_data_plane_rx;
  logic clk = 0, rst = 1, flag = 0, pop = 0;
  logic [15:0] node_id = 16'h0005;
  logic [31:0] pkt = 0;
  logic b_cmp, b_err, b_ovf, b_vld, s_cmp, s_err, s_ovf, s_vld;
  logic [15:0] b_src, b_rd, s_src, s_rd;
  logic [4:0] b_sp;
  logic [2:0] s_sp;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  data_plane_rx #(.PKT_WORDS(4), .ADDR_W(4)) u_big (
    .clk(clk), .rst(rst), .node_id(node_id), .data_rx_flag(flag), .data_rx_packet(pkt),
    .data_rx_complete_flag(b_cmp), .data_rx_error_flag(b_err), .rx_src_node(b_src),
    .rx_overflow(b_ovf), .gpp_rx_pop(pop), .gpp_rx_data(b_rd), .gpp_rx_valid(b_vld),
    .sp_rx_current(b_sp));
  data_plane_rx #(.PKT_WORDS(4), .ADDR_W(2)) u_small (
    .clk(clk), .rst(rst), .node_id(node_id), .data_rx_flag(flag), .data_rx_packet(pkt),
    .data_rx_complete_flag(s_cmp), .data_rx_error_flag(s_err), .rx_src_node(s_src),
    .rx_overflow(s_ovf), .gpp_rx_pop(pop), .gpp_rx_data(s_rd), .gpp_rx_valid(s_vld),
    .sp_rx_current(s_sp));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic [31:0] p);
    pkt = p;
    @(posedge clk);
    #1;
  endtask
  task automatic flags(input string tag, input logic cmp, input logic err);
    chk({tag, " b_cmp"}, 32'(b_cmp), 32'(cmp));
    chk({tag, " b_err"}, 32'(b_err), 32'(err));
    chk({tag, " s_cmp"}, 32'(s_cmp), 32'(cmp));
    chk({tag, " s_err"}, 32'(s_err), 32'(err));
  endtask
  logic [15:0] exp_pop [4] = '{16'h4444, 16'h3333, 16'h2222, 16'h1111};
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst b_sp", 32'(b_sp), 0);
    chk("rst s_sp", 32'(s_sp), 0);
    chk("rst src", 32'(b_src), 0);
    chk("rst ovf", 32'(b_ovf), 0);
    chk("rst vld", 32'(b_vld), 0);
    chk("rst rd", 32'(b_rd), 0);
    flags("rst", 0, 0);
    // basic frame
    flag = 1;
    step(0);
    step(32'h0005_0009);
    chk("hdr src", 32'(b_src), 32'h9);
    step(32'h0005_1111);
    step(32'h0005_2222);
    step(32'h0005_3333);
    flags("word3", 0, 0);
    chk("word3 sp", 32'(b_sp), 3);
    step(32'h0005_4444);
    flags("word4", 1, 0);
    chk("word4 b_sp", 32'(b_sp), 4);
    chk("word4 s_sp", 32'(s_sp), 4);
    chk("word4 s_ovf", 32'(s_ovf), 0);
    flag = 0;
    step(0);
    flags("after cmp", 0, 0);
    // LIFO drain then an empty pop
    pop = 1;
    for (int i = 0; i < 4; i++) begin
      step(0);
      chk("pop b_rd", 32'(b_rd), 32'(exp_pop[i]));
      chk("pop s_rd", 32'(s_rd), 32'(exp_pop[i]));
      chk("pop vld", 32'(b_vld), 1);
      chk("pop sp", 32'(b_sp), 32'(3 - i));
    end
    step(0);
    chk("empty pop vld", 32'(b_vld), 0);
    chk("empty pop s_vld", 32'(s_vld), 0);
    chk("empty pop sp", 32'(b_sp), 0);
    pop = 0;
    // fill 4 words, pop 2 to leave sp=2
    flag = 1;
    step(0);
    step(32'h0005_0002);
    step(32'h0005_00A1);
    step(32'h0005_00A2);
    step(32'h0005_00A3);
    step(32'h0005_00A4);
    flag = 0;
    pop = 1;
    step(0);
    chk("pop a4", 32'(b_rd), 32'h00A4);
    step(0);
    chk("pop a3", 32'(b_rd), 32'h00A3);
    chk("sp2", 32'(b_sp), 2);
    pop = 0;
    // error frame rolls back
    flag = 1;
    step(0);
    step(32'h0005_000B);
    step(32'h0005_AAAA);
    chk("partial sp", 32'(b_sp), 3);
    step(32'h0007_BBBB);
    flags("err", 0, 1);
    chk("err b_sp", 32'(b_sp), 2);
    chk("err s_sp", 32'(s_sp), 2);
    step(0);
    flags("after err", 0, 0);
    // foreign header ignored, own header accepted, small stack overflows
    step(32'h0007_0001);
    chk("foreign hdr src", 32'(b_src), 32'hB);
    step(32'h0005_0033);
    chk("hdr2 src", 32'(b_src), 32'h33);
    step(32'h0005_C001);
    step(32'h0005_C002);
    chk("s_ovf pre", 32'(s_ovf), 0);
    step(32'h0005_C003);
    chk("s_ovf set", 32'(s_ovf), 1);
    flags("c3", 0, 0);
    step(32'h0005_C004);
    flags("ovf cmp", 1, 0);
    chk("ovf s_sp", 32'(s_sp), 4);
    chk("ovf b_sp", 32'(b_sp), 6);
    chk("ovf b_ovf", 32'(b_ovf), 0);
    flag = 0;
    pop = 1;
    step(0);
    chk("post ovf b_rd", 32'(b_rd), 32'hC004);
    chk("post ovf s_rd", 32'(s_rd), 32'hC002);
    chk("post ovf s_vld", 32'(s_vld), 1);
    chk("post ovf s_sp", 32'(s_sp), 3);
    chk("s_ovf sticky", 32'(s_ovf), 1);
    pop = 0;
    // pop concurrent with header; frame_sp takes post-pop value; pops ignored in RECV
    flag = 1;
    step(0);
    pop = 1;
    step(32'h0005_0044);
    chk("hdr+pop b_rd", 32'(b_rd), 32'hC003);
    chk("hdr+pop b_sp", 32'(b_sp), 4);
    chk("hdr+pop s_sp", 32'(s_sp), 2);
    chk("hdr+pop src", 32'(b_src), 32'h44);
    step(32'h0005_D001);
    chk("recv pop vld", 32'(b_vld), 0);
    chk("recv push sp", 32'(b_sp), 5);
    pop = 0;
    step(32'h0006_0000);
    flags("rollback", 0, 1);
    chk("rollback b_sp", 32'(b_sp), 4);
    chk("rollback s_sp", 32'(s_sp), 2);
    step(0);
    // reset mid-frame
    step(32'h0005_0055);
    step(32'h0005_E001);
    step(32'h0005_E002);
    chk("mid b_sp", 32'(b_sp), 6);
    rst = 1;
    flag = 0;
    step(0);
    chk("mid rst b_sp", 32'(b_sp), 0);
    chk("mid rst s_sp", 32'(s_sp), 0);
    chk("mid rst src", 32'(b_src), 0);
    chk("mid rst s_ovf", 32'(s_ovf), 0);
    chk("mid rst rd", 32'(b_rd), 0);
    flags("mid rst", 0, 0);
    rst = 0;
    step(32'h0005_0077);
    chk("unarmed hdr src", 32'(b_src), 0);
    step(32'h0005_E003);
    chk("unarmed sp", 32'(b_sp), 0);
    flags("unarmed", 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
